uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
//  Boot-time program loader between the UART byte receiver and the instruction-RAM write port.
//  Parses a framed byte stream: start byte, word count, payload, XOR checksum.
//  Emits one 32-bit instruction-RAM write per received word.
//  Holds the core in reset until a frame completes with a good checksum, then releases it.
// PARAMETERS
//  ADDR_W      14        instruction-RAM word-address width; max words = 2**ADDR_W
//  START_BYTE  8'hA5     frame start marker
//  TIMEOUT     1000000   max clk_i cycles between bytes inside a frame; counter width = $clog2(TIMEOUT+1)
// PORTS
//  clk_i        in   1       system clock
//  rst_i        in   1       asynchronous reset, active-high
//  rx_dv_i      in   1       1-cycle strobe: rx_byte_i valid
//  rx_byte_i    in   8       received UART byte
//  we_o         out  1       1-cycle instruction-RAM write strobe
//  addr_o       out  ADDR_W  word address for we_o
//  wdata_o      out  32      write data for we_o
//  core_rst_no  out  1       core reset, active-low; 0 = core held
//  busy_o       out  1       frame in progress (state LEN0..CSUM)
//  done_o       out  1       sticky; load completed OK
//  err_o        out  1       sticky until next START_BYTE; last frame failed
// BEHAVIOUR
//  Reset values
//   - All outputs 0; core held.
//   - state=IDLE; word counter, byte index, checksum and timer cleared.
//  States
//   - IDLE: rx_dv_i with START_BYTE -> LEN0 (clears err_o, csum, word index); other bytes ignored.
//   - LEN0: latch N[7:0] -> LEN1.
//   - LEN1: latch N[15:8].
//       - N > 2**ADDR_W -> ERR.
//       - N == 0 -> CSUM.
//       - else -> DATA.
//   - DATA: assemble bytes little-endian (first byte = wdata[7:0]); csum ^= byte on every data byte.
//       - On 4th byte, next cycle: we_o=1, addr_o=word index, wdata_o=word; word index++.
//       - After word N-1 -> CSUM.
//   - CSUM: compare byte with csum (XOR of payload bytes only; start/length bytes excluded).
//       - match -> DONE; mismatch -> ERR.
//   - DONE: done_o=1, core_rst_no=1; all further bytes ignored until rst_i.
//   - ERR: err_o=1, core held, busy_o=0; behaves as IDLE (START_BYTE restarts a frame).
//  Timing
//   - we_o latency: exactly 1 cycle after the rx_dv_i of the 4th byte; never asserted outside DATA.
//   - addr_o/wdata_o hold their last value between strobes.
//   - Timer: reset on every rx_dv_i.
//       - Counts while busy_o; reaching TIMEOUT -> ERR.
//       - Words already written are not rolled back.
//  Boundary conditions
//   - addr_o never wraps (N bounded); last legal address = 2**ADDR_W-1.
//   - rx_dv_i on consecutive cycles must be accepted (no byte dropped).
//   - rst_i mid-frame: immediate abort; all outputs to reset values; no partial we_o.
//   - done_o and err_o are never 1 together.
// TESTING
//  1. Bytes A5 02 00 01 02 03 04 05 06 07 08 08:
//       - we_o @addr 0 = 0x04030201, then @addr 1 = 0x08070605.
//       - done_o=1, core_rst_no=1.
//  2. Same frame with checksum byte 0x09:
//       - two writes occur; err_o=1, core_rst_no=0.
//       - Resend test 1 frame -> done_o=1.
//  3. A5 00 00 00 -> no we_o; done_o=1.
//  4. 11 22 then test 1 frame -> leading bytes ignored; result as test 1.
//  5. A5 01 00 AA, then idle for TIMEOUT cycles -> err_o=1, busy_o=0, no we_o.
//  6. A5 01 40 (N=0x4001, ADDR_W=14) -> err_o=1 after LEN1.
//  7. rst_i pulse after 2 payload bytes -> outputs 0; a full test 1 frame then succeeds.
//  8. Payload bytes with 1-cycle spacing, back-to-back -> all words correct.

Source files
------------

// File: rtl/uart_prog_loader.sv
// Boot-time program loader: parses A5/len/payload/xor frames from the UART
// receiver into instruction-RAM writes and releases the core on success.
module uart_prog_loader #(
  parameter int         ADDR_W     = 14,
  parameter logic [7:0] START_BYTE = 8'hA5,
  parameter int         TIMEOUT    = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic              core_rst_no,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int          TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMAX = TMR_W'(TIMEOUT);
  localparam logic [63:0] MAX_N = 64'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      len;
  logic [15:0]      word_idx;
  logic [1:0]       byte_idx;
  logic [31:0]      shreg;
  logic [7:0]       csum;
  logic [TMR_W-1:0] timer;
  logic [63:0]      n_ext;
  logic             timed_out;
  logic             last_word;
  logic             is_start;

  // Status flags decode straight from the state register.
  assign busy_o      = (state == S_LEN0) || (state == S_LEN1) ||
                       (state == S_DATA) || (state == S_CSUM);
  assign done_o      = (state == S_DONE);
  assign err_o       = (state == S_ERR);
  assign core_rst_no = (state == S_DONE);

  // Full word count once the high length byte arrives (low byte latched).
  assign n_ext     = {48'd0, rx_byte_i, len[7:0]};
  assign last_word = (word_idx == len - 16'd1);
  assign is_start  = (rx_byte_i == START_BYTE);
  assign timed_out = busy_o && !rx_dv_i && (timer == TMAX);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a byte gap timeout overrides everything while busy.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_ERR: begin
        if (rx_dv_i && is_start) state_nxt = S_LEN0;
      end
      S_LEN0: begin
        if (rx_dv_i) state_nxt = S_LEN1;
      end
      S_LEN1: begin
        if (rx_dv_i) begin
          if (n_ext > MAX_N)      state_nxt = S_ERR;
          else if (n_ext == '0)   state_nxt = S_CSUM;
          else                    state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_dv_i && byte_idx == 2'd3 && last_word)
          state_nxt = S_CSUM;
      end
      S_CSUM: begin
        if (rx_dv_i)
          state_nxt = (rx_byte_i == csum) ? S_DONE : S_ERR;
      end
      S_DONE: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (timed_out) state_nxt = S_ERR;
  end

  // Byte gap timer: restarts on each byte, saturates at the limit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer <= '0;
    end else if (!busy_o || rx_dv_i) begin
      timer <= '0;
    end else if (timer != TMAX) begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Frame datapath: length, little-endian word assembly, checksum, writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_o     <= 1'b0;
      addr_o   <= '0;
      wdata_o  <= '0;
      len      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      csum     <= '0;
    end else begin
      we_o <= 1'b0;
      if (rx_dv_i) begin
        unique case (state)
          S_IDLE, S_ERR: begin
            if (is_start) begin
              csum     <= '0;
              word_idx <= '0;
              byte_idx <= '0;
            end
          end
          S_LEN0: len[7:0]  <= rx_byte_i;
          S_LEN1: len[15:8] <= rx_byte_i;
          S_DATA: begin
            csum     <= csum ^ rx_byte_i;
            byte_idx <= byte_idx + 2'd1;
            shreg[{byte_idx, 3'b000} +: 8] <= rx_byte_i;
            if (byte_idx == 2'd3) begin
              we_o     <= 1'b1;
              addr_o   <= ADDR_W'(word_idx);
              wdata_o  <= {rx_byte_i, shreg[23:0]};
              word_idx <= word_idx + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: expected RAM writes are queued
// by the stimulus and checked by an independent write monitor.
module tb_uart_prog_loader;

  localparam int ADDR_W  = 14;
  localparam int TIMEOUT = 50;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_dv = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] tx_q[$];
  int         total = 0;
  int         bad = 0;

  uart_prog_loader #(
    .ADDR_W    (ADDR_W),
    .START_BYTE(8'hA5),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_dv_i    (rx_dv),
    .rx_byte_i  (rx_byte),
    .we_o       (we),
    .addr_o     (addr),
    .wdata_o    (wdata),
    .core_rst_no(core_rst_n),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h want none",
                 addr, wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(addr), 32'(mon_e.a));
        chk("wr_data", wdata, mon_e.d);
      end
    end
    if (!rst) chk("done_err_excl", 32'(done && err), 32'd0);
  end

  task automatic send(input int gap);
    while (tx_q.size() > 0) begin
      rx_dv   = 1'b1;
      rx_byte = tx_q.pop_front();
      @(negedge clk);
      rx_dv = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_dv = 1'b0;
  endtask

  task automatic wait_c(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_c(2);
    rst = 1'b0;
    wait_c(1);
  endtask

  task automatic chk_stat(input string nm, input logic d, input logic e,
                          input logic c, input logic b);
    chk({nm, "_done"}, 32'(done), 32'(d));
    chk({nm, "_err"},  32'(err),  32'(e));
    chk({nm, "_core"}, 32'(core_rst_n), 32'(c));
    chk({nm, "_busy"}, 32'(busy), 32'(b));
  endtask

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t w;
    w.a = ADDR_W'(a);
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic frame1(input logic [7:0] cs, input int gap);
    push_wr(0, 32'h04030201);
    push_wr(1, 32'h08070605);
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
             8'h05, 8'h06, 8'h07, 8'h08, cs};
    send(gap);
    wait_c(3);
  endtask

  initial begin
    wait_c(3);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk_stat("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    wait_c(1);

    // Basic two-word frame; checksum 01^..^08 = 08.
    frame1(8'h08, 2);
    chk("t1_pending", 32'(exp_q.size()), 32'd0);
    chk_stat("t1", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t1_addr_hold", 32'(addr), 32'd1);
    chk("t1_wdata_hold", wdata, 32'h08070605);
    // Once done, a further frame must be ignored entirely.
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send(1);
    wait_c(3);
    chk_stat("t1_locked", 1'b1, 1'b0, 1'b1, 1'b0);

    // Bad checksum: writes still happen, then error; a good resend recovers.
    do_reset();
    frame1(8'h09, 1);
    chk("t2_pending", 32'(exp_q.size()), 32'd0);
    chk_stat("t2", 1'b0, 1'b1, 1'b0, 1'b0);
    frame1(8'h08, 1);
    chk("t2r_pending", 32'(exp_q.size()), 32'd0);
    chk_stat("t2r", 1'b1, 1'b0, 1'b1, 1'b0);

    // Zero-length frame.
    do_reset();
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send(1);
    wait_c(3);
    chk_stat("t3", 1'b1, 1'b0, 1'b1, 1'b0);

    // Leading garbage is ignored.
    do_reset();
    tx_q = '{8'h11, 8'h22};
    send(1);
    wait_c(2);
    chk_stat("t4_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    frame1(8'h08, 1);
    chk("t4_pending", 32'(exp_q.size()), 32'd0);
    chk_stat("t4", 1'b1, 1'b0, 1'b1, 1'b0);

    // Byte-gap timeout inside a frame.
    do_reset();
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'hAA};
    send(1);
    wait_c(30);
    chk_stat("t5_wait", 1'b0, 1'b0, 1'b0, 1'b1);
    wait_c(30);
    chk_stat("t5", 1'b0, 1'b1, 1'b0, 1'b0);

    // Oversized length, restarted straight from the error state.
    tx_q = '{8'hA5, 8'h01, 8'h40};
    send(1);
    wait_c(2);
    chk_stat("t6", 1'b0, 1'b1, 1'b0, 1'b0);
    // Exactly 2**ADDR_W words is legal: frame proceeds into payload.
    tx_q = '{8'hA5, 8'h00, 8'h40};
    send(1);
    wait_c(2);
    chk_stat("t6_max", 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a word.
    do_reset();
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02};
    send(0);
    rst = 1'b1;
    wait_c(1);
    chk("t7_we", 32'(we), 32'd0);
    chk("t7_addr", 32'(addr), 32'd0);
    chk("t7_wdata", wdata, 32'd0);
    chk_stat("t7_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    wait_c(1);
    frame1(8'h08, 0);
    chk("t7_pending", 32'(exp_q.size()), 32'd0);
    chk_stat("t7", 1'b1, 1'b0, 1'b1, 1'b0);

    // Back-to-back three-word frame; checksum = CC.
    do_reset();
    push_wr(0, 32'h44332211);
    push_wr(1, 32'h88776655);
    push_wr(2, 32'hCCBBAA99);
    tx_q = '{8'hA5, 8'h03, 8'h00,
             8'h11, 8'h22, 8'h33, 8'h44,
             8'h55, 8'h66, 8'h77, 8'h88,
             8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCC};
    send(0);
    wait_c(3);
    chk("t8_pending", 32'(exp_q.size()), 32'd0);
    chk_stat("t8", 1'b1, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
